// File: rtl/fetch_control_if.sv
// Fetch-unit bus: hazard/redirect inputs, instruction-ROM port, IF/ID register and status outputs.
interface fetch_control_if;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic        IfIdValid;
  logic [31:0] IfIdPC;
  logic [31:0] IfIdPCPlus4;
  logic [31:0] IfIdInstruction;
  logic        Fault;
  logic [1:0]  FaultCode;
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;

  modport master (
    input  Stall, Redirect, RedirectTarget, ImemInstruction,
    output ImemAddress, IfIdValid, IfIdPC, IfIdPCPlus4, IfIdInstruction,
           Fault, FaultCode, FetchCount, BubbleCount
  );

  modport slave (
    output Stall, Redirect, RedirectTarget, ImemInstruction,
    input  ImemAddress, IfIdValid, IfIdPC, IfIdPCPlus4, IfIdInstruction,
           Fault, FaultCode, FetchCount, BubbleCount
  );
endinterface

// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: PC, IF/ID register, stall/redirect handling and fetch-fault detection.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_control #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input logic             clk,
  input logic             reset_n,
  fetch_control_if.master bus
);
  localparam int unsigned XLEN = 32;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE    = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;

  logic redirect_misaligned;
  logic pc_out_of_range;

  assign redirect_misaligned = bus.Redirect && (bus.RedirectTarget[1:0] != 2'b00);
  assign pc_out_of_range     = {2'b00, pc_q[31:2]} >= IMEM_WORDS;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state and next-register logic; RUN decisions in priority order
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_misaligned) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FC_MISALIGN;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else if (bus.Redirect) begin
          pc_d         = bus.RedirectTarget;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else if (bus.Stall) begin
          pc_d = pc_q;
        end else if (pc_out_of_range) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FC_RANGE;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else begin
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_q + XLEN'(4);
          ifid_instr_d = bus.ImemInstruction;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + XLEN'(4);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.ImemAddress     = pc_q;
  assign bus.IfIdValid       = ifid_valid_q;
  assign bus.IfIdPC          = ifid_pc_q;
  assign bus.IfIdPCPlus4     = ifid_pc4_q;
  assign bus.IfIdInstruction = ifid_instr_q;
  assign bus.Fault           = fault_q;
  assign bus.FaultCode       = fault_code_q;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetch_count_q;
  logic [XLEN-1:0] bubble_count_q;
  logic            run_fetch;
  logic            run_bubble;

  assign run_fetch  = (state_q == ST_RUN) && !bus.Redirect && !bus.Stall && !pc_out_of_range;
  assign run_bubble = (state_q == ST_RUN) &&
                      (bus.Stall || (bus.Redirect && !redirect_misaligned));

  // Saturating counters; only RUN cycles count, so they freeze in FAULT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (run_fetch && (fetch_count_q != '1)) begin
        fetch_count_q <= fetch_count_q + XLEN'(1);
      end
      if (run_bubble && (bubble_count_q != '1)) begin
        bubble_count_q <= bubble_count_q + XLEN'(1);
      end
    end
  end

  assign bus.FetchCount  = fetch_count_q;
  assign bus.BubbleCount = bubble_count_q;
`else
  assign bus.FetchCount  = '0;
  assign bus.BubbleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed vector table, corner sequences, random run vs model.
module tb_fetch_control;
  localparam int unsigned IMEM_WORDS = 256;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fetch_control_if bus();

  fetch_control #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [31:0] rom [IMEM_WORDS];
  assign bus.ImemInstruction = (bus.ImemAddress < 32'(IMEM_WORDS * 4)) ?
                               rom[bus.ImemAddress[9:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] rom_read(input logic [31:0] addr);
    if ((addr / 4) < IMEM_WORDS) return rom[addr[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: what the fetch unit should hold after each edge
  bit          m_boot, m_fault, m_valid;
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_fetch, m_bub;
  logic [1:0]  m_code;

  task automatic model_reset();
    m_boot = 1'b1; m_fault = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_instr = 32'h0;
    m_fetch = 32'h0; m_bub = 32'h0; m_code = 2'd0;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] t);
    bit aligned;
    aligned = (t % 4) == 0;
    if (m_fault) return;
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    if ((s || (r && aligned)) && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    if (r && !aligned) begin
      m_fault = 1'b1; m_code = 2'd1; m_valid = 1'b0; m_instr = 32'h0;
    end else if (r) begin
      m_pc = t; m_valid = 1'b0; m_instr = 32'h0;
    end else if (s) begin
      // hold everything
    end else if (m_pc / 4 >= IMEM_WORDS) begin
      m_fault = 1'b1; m_code = 2'd2; m_valid = 1'b0; m_instr = 32'h0;
    end else begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = rom_read(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 4;
      if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr"},   bus.ImemAddress, m_pc);
    chk({tag, ".valid"},  32'(bus.IfIdValid), 32'(m_valid));
    chk({tag, ".ifpc"},   bus.IfIdPC, m_ifpc);
    chk({tag, ".ifpc4"},  bus.IfIdPCPlus4, m_ifpc4);
    chk({tag, ".instr"},  bus.IfIdInstruction, m_instr);
    chk({tag, ".fault"},  32'(bus.Fault), 32'(m_fault));
    chk({tag, ".code"},   32'(bus.FaultCode), 32'(m_code));
    chk({tag, ".fetchc"}, bus.FetchCount, PERF ? m_fetch : 32'h0);
    chk({tag, ".bubc"},   bus.BubbleCount, PERF ? m_bub : 32'h0);
  endtask

  task automatic tick(input bit s, input bit r, input logic [31:0] t);
    bus.Stall = s; bus.Redirect = r; bus.RedirectTarget = t;
    @(posedge clk);
    model_step(s, r, t);
    #1;
  endtask

  // Asynchronous reset pulse away from the clock edge; release on the falling edge
  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          stall;
    bit          redir;
    logic [31:0] tgt;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    bit          fault;
    logic [1:0]  code;
    logic [31:0] fetchc;
    logic [31:0] bubc;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit r, input logic [31:0] t, input bit v,
                              input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] a,
                              input bit f, input logic [1:0] c, input logic [31:0] fc,
                              input logic [31:0] bc);
    vec_t x;
    x.stall = s; x.redir = r; x.tgt = t; x.valid = v; x.pc = pc; x.instr = ins;
    x.addr = a; x.fault = f; x.code = c; x.fetchc = fc; x.bubc = bc;
    return x;
  endfunction

  vec_t vecs[11];

  initial begin
    bit          s, r;
    logic [31:0] t;
    int          sel;

    for (int i = 0; i < int'(IMEM_WORDS); i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0001; rom[1] = 32'h2009_0002; rom[2] = 32'h0109_5020; rom[3] = 32'h0;
    rom[16] = 32'h8C0B_0040;

    // One row per edge after reset release (edge 1 is BOOT, inputs there are ignored)
    vecs[0]  = mk(1'b1, 1'b1, 32'h80, 1'b0, 32'h0,  32'h0,         32'h0,  1'b0, 2'd0, 32'd0, 32'd0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h2008_0001, 32'h4,  1'b0, 2'd0, 32'd1, 32'd0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h2009_0002, 32'h8,  1'b0, 2'd0, 32'd2, 32'd0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h2009_0002, 32'h8,  1'b0, 2'd0, 32'd2, 32'd1);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h2009_0002, 32'h8,  1'b0, 2'd0, 32'd2, 32'd2);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h2009_0002, 32'h8,  1'b0, 2'd0, 32'd2, 32'd3);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h0109_5020, 32'hC,  1'b0, 2'd0, 32'd3, 32'd3);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  32'h0,         32'h10, 1'b0, 2'd0, 32'd4, 32'd3);
    vecs[8]  = mk(1'b1, 1'b1, 32'h40, 1'b0, 32'hC,  32'h0,         32'h40, 1'b0, 2'd0, 32'd4, 32'd4);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 32'h8C0B_0040, 32'h44, 1'b0, 2'd0, 32'd5, 32'd4);
    vecs[10] = mk(1'b0, 1'b1, 32'h42, 1'b0, 32'h40, 32'h0,         32'h44, 1'b1, 2'd1, 32'd5, 32'd4);

    bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectTarget = 32'h0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      tick(vecs[i].stall, vecs[i].redir, vecs[i].tgt);
      check_model(tag);
      chk({tag, ".t_valid"}, 32'(bus.IfIdValid), 32'(vecs[i].valid));
      chk({tag, ".t_ifpc"},  bus.IfIdPC, vecs[i].pc);
      if (i > 0) chk({tag, ".t_ifpc4"}, bus.IfIdPCPlus4, vecs[i].pc + 32'd4);
      if (!vecs[i].fault) chk({tag, ".t_instr"}, bus.IfIdInstruction, vecs[i].instr);
      chk({tag, ".t_addr"},  bus.ImemAddress, vecs[i].addr);
      chk({tag, ".t_fault"}, 32'(bus.Fault), 32'(vecs[i].fault));
      chk({tag, ".t_code"},  32'(bus.FaultCode), 32'(vecs[i].code));
      chk({tag, ".t_fetchc"}, bus.FetchCount, PERF ? vecs[i].fetchc : 32'h0);
      chk({tag, ".t_bubc"},   bus.BubbleCount, PERF ? vecs[i].bubc : 32'h0);
    end

    // Fault is terminal: random stimulus must not revive fetch
    for (int i = 0; i < 10; i++) begin
      tick(1'($urandom), 1'($urandom), $urandom & 32'h3FC);
      check_model("sticky");
      chk("sticky.valid", 32'(bus.IfIdValid), 32'h0);
      chk("sticky.addr",  bus.ImemAddress, 32'h44);
      chk("sticky.code",  32'(bus.FaultCode), 32'd1);
    end

    // Mid-run asynchronous reset, then restart through BOOT
    pulse_reset("rst0");
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      check_model("prerun");
    end
    chk("prerun.valid", 32'(bus.IfIdValid), 32'h1);
    pulse_reset("rst_mid");
    chk("rst_mid.addr", bus.ImemAddress, 32'h0);
    chk("rst_mid.valid", 32'(bus.IfIdValid), 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check_model("reboot1");
    chk("reboot1.valid", 32'(bus.IfIdValid), 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check_model("reboot2");
    chk("reboot2.instr", bus.IfIdInstruction, 32'h2008_0001);

    // Run off the end of the ROM
    tick(1'b0, 1'b1, 32'h3F8);
    check_model("top.redir");
    tick(1'b0, 1'b0, 32'h0);
    check_model("top.3f8");
    tick(1'b0, 1'b0, 32'h0);
    check_model("top.3fc");
    chk("top.3fc.ifpc",  bus.IfIdPC, 32'h3FC);
    chk("top.3fc.instr", bus.IfIdInstruction, rom[255]);
    tick(1'b0, 1'b0, 32'h0);
    check_model("top.400");
    chk("top.400.code", 32'(bus.FaultCode), 32'd2);
    chk("top.400.addr", bus.ImemAddress, 32'h400);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      chk("top.hold.addr", bus.ImemAddress, 32'h400);
    end

    // Randomized run against the model
    pulse_reset("rnd.rst");
    for (int n = 0; n < 1500; n++) begin
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        pulse_reset("rnd.rst");
        continue;
      end
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      sel = int'($urandom_range(0, 99));
      if (sel < 80)      t = 32'($urandom_range(0, 255)) << 2;
      else if (sel < 90) t = 32'h3E0 + (32'($urandom_range(0, 7)) << 2);
      else if (sel < 95) t = $urandom & 32'hFFFF_FFFC;
      else               t = ($urandom & 32'h3FC) | 32'($urandom_range(1, 3));
      tick(s, r, t);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
# fetch_control

Instruction-fetch sequencer for the MIPS pipeline. It owns the program counter and drives the address of the 256-word combinational instruction ROM. It captures the returned word into the IF/ID pipeline register. It applies hazard-unit stalls and EX-stage branch/jump redirects, and it stops fetching with a fault flag on misaligned or out-of-range fetch addresses.

## Interface
- `RESET_PC`, 32'h00000000, PC value loaded at reset; must be word-aligned.
- `IMEM_WORDS`, 256, instruction memory depth in 32-bit words; fetch index is `PC[31:2]`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Stall`  in  1  hazard unit: hold PC and IF/ID.
- `Redirect`  in  1  taken branch/jump resolved in EX.
- `RedirectTarget`  in  32  new PC when `Redirect`=1.
- `ImemAddress`  out  32  to instruction memory `Address`; equals PC register.
- `ImemInstruction`  in  32  from instruction memory; combinational, valid in the same cycle.
- `IfIdValid`  out  1  IF/ID holds a live instruction.
- `IfIdPC`  out  32  PC of the IF/ID instruction.
- `IfIdPCPlus4`  out  32  `IfIdPC`+4.
- `IfIdInstruction`  out  32  fetched word; 0 (NOP) when invalid.
- `Fault`  out  1  sticky; fetch has stopped.
- `FaultCode`  out  2  0=none, 1=misaligned redirect, 2=PC out of range.
- `FetchCount`  out  32  retired fetches (see Configuration).
- `BubbleCount`  out  32  squash/stall cycles (see Configuration).

## Operation
- States: BOOT, RUN, FAULT. Reset enters BOOT.
- BOOT: lasts exactly one cycle. No IF/ID load. `Stall` and `Redirect` are ignored. Next state is RUN.
- RUN, evaluated each cycle, priority top-down:
  - `Redirect`=1 with `RedirectTarget[1:0]`≠0: go to FAULT, `FaultCode`=1, `IfIdValid`←0, PC held.
  - `Redirect`=1 and aligned: PC←`RedirectTarget`, `IfIdValid`←0, `IfIdInstruction`←0. The wrong-path instruction is squashed. Redirect overrides `Stall`.
  - `Stall`=1: PC and all IF/ID outputs hold their values.
  - `PC[31:2]`≥`IMEM_WORDS`: go to FAULT, `FaultCode`=2, `IfIdValid`←0. The word is not latched.
  - Otherwise: `IfIdPC`←PC, `IfIdPCPlus4`←PC+4, `IfIdInstruction`←`ImemInstruction`, `IfIdValid`←1, PC←PC+4.
- FAULT: terminal until reset. PC and IF/ID fields are frozen, `IfIdValid`=0, and all inputs are ignored.
- Arithmetic: PC+4 is modulo 2^32. The range check always catches the address before any wrap is used.
- The range check applies only to the current PC. A redirect to an aligned out-of-range target is accepted and faults on the next non-stalled RUN cycle.

## Timing
- Reset values: PC=`ImemAddress`=`RESET_PC`, `IfIdValid`=0, `IfIdPC`=0, `IfIdPCPlus4`=0, `IfIdInstruction`=0, `Fault`=0, `FaultCode`=0, both counters 0.
- Reset deassertion is edge 0. Edge 1 leaves BOOT. Edge 2 latches the word at `RESET_PC`, so `IfIdValid`=1 after edge 2.
- Fetch latency: word at `ImemAddress` in cycle n appears on IF/ID after edge n+1. Throughput is one instruction per cycle.
- Redirect asserted in cycle n: `ImemAddress`=`RedirectTarget` in cycle n+1, and the target instruction is valid in IF/ID after edge n+2. This gives exactly one bubble.
- `Fault` rises the cycle after the triggering edge condition, i.e. it is registered.
- Asserting `reset_n`=0 mid-operation clears everything immediately (asynchronously) and restarts from BOOT.

## Configuration
- `FETCH_PERF_EN` defined:
  - `FetchCount` increments on every IF/ID load with `IfIdValid`←1.
  - `BubbleCount` increments on every RUN cycle with `Stall`=1 or an aligned `Redirect`=1.
  - Both counters saturate at 32'hFFFFFFFF, freeze in FAULT, and clear on reset.
- `FETCH_PERF_EN` undefined: no counter registers are built, and `FetchCount` and `BubbleCount` are tied to 0.

## Test plan
- Reset release, ROM words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000, no stall or redirect:
  - `IfIdValid`=1 from edge 2.
  - `IfIdPC`=0,4,8,12 on consecutive edges, with the matching instructions.
  - `IfIdPCPlus4`=`IfIdPC`+4.
- Stall for 3 cycles while `IfIdPC`=4:
  - IF/ID and `ImemAddress`=8 are held for 3 edges, then fetch resumes at 8.
  - With `FETCH_PERF_EN`, `BubbleCount`=3.
- `Redirect`=1 with `RedirectTarget`=0x40, while `Stall`=1, `ImemAddress`=0x10:
  - Next cycle `IfIdValid`=0, `ImemAddress`=0x40.
  - One cycle later `IfIdPC`=0x40.
- `RedirectTarget`=0x42:
  - `Fault`=1, `FaultCode`=1 next cycle.
  - `IfIdValid` stays 0 for 10 further cycles despite stimulus.
- Sequential run to PC=0x3FC, then 0x400 with `IMEM_WORDS`=256:
  - The 0x3FC word is latched.
  - Next, `FaultCode`=2 and `ImemAddress` stays 0x400.
- `reset_n` pulsed low mid-run while `IfIdValid`=1:
  - All outputs reach reset values without a clock edge.
  - Fetch restarts at `RESET_PC` after BOOT.
